// File: rtl/memory_controller.sv
// NBBPU memory responder: arbitrates instruction fetches and data accesses onto one
// single-port synchronous word RAM, one access per two cycles, data before fetch.
module memory_controller #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] PC,
    input  logic        fetch_request,
    output logic [15:0] instruction,
    output logic        instruction_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] address,
    input  logic [15:0] write_data,
    output logic [15:0] read_data,
    output logic        data_valid,
    output logic        busy,
    output logic        error
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        DATA_WAIT  = 2'd1,
        FETCH_WAIT = 2'd2
    } state_t;

    state_t                 state_r;
    logic [15:0]            mem_r [0:DEPTH-1];
    logic [ADDR_BITS-1:0]   data_idx_s;
    logic [ADDR_BITS-1:0]   fetch_idx_s;
    logic                   write_en_s;
    logic                   unused_addr_bits_s;

    // Byte address to word index; bit 0 and bits above the RAM range are dropped.
    function automatic logic [ADDR_BITS-1:0] word_index(input logic [15:0] byte_addr);
        return byte_addr[ADDR_BITS:1];
    endfunction

    assign unused_addr_bits_s = ^{address, PC};

    // Decode word indices and the RAM write strobe for the current IDLE cycle.
    always_comb begin
        data_idx_s  = word_index(address);
        fetch_idx_s = word_index(PC);
        if (!reset && (state_r == IDLE) && mem_write) begin
            write_en_s = 1'b1;
        end else begin
            write_en_s = 1'b0;
        end
    end

    // RAM write port; deliberately not reset so contents survive a controller reset.
    always_ff @(posedge clock) begin
        if (write_en_s) begin
            mem_r[data_idx_s] <= write_data;
        end
    end

    // Access sequencer with registered read results, valid pulses and sticky error.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r           <= IDLE;
            instruction       <= 16'h0000;
            read_data         <= 16'h0000;
            instruction_valid <= 1'b0;
            data_valid        <= 1'b0;
            error             <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    // The RAM read happens here so the result is visible with the valid pulse.
                    if (mem_write) begin
                        state_r           <= DATA_WAIT;
                        data_valid        <= 1'b1;
                        instruction_valid <= 1'b0;
                        if (mem_read || address[0]) begin
                            error <= 1'b1;
                        end
                    end else if (mem_read) begin
                        state_r           <= DATA_WAIT;
                        read_data         <= mem_r[data_idx_s];
                        data_valid        <= 1'b1;
                        instruction_valid <= 1'b0;
                        if (address[0]) begin
                            error <= 1'b1;
                        end
                    end else if (fetch_request) begin
                        state_r           <= FETCH_WAIT;
                        instruction       <= mem_r[fetch_idx_s];
                        instruction_valid <= 1'b1;
                        data_valid        <= 1'b0;
                        if (PC[0]) begin
                            error <= 1'b1;
                        end
                    end else begin
                        state_r           <= IDLE;
                        data_valid        <= 1'b0;
                        instruction_valid <= 1'b0;
                    end
                end
                DATA_WAIT, FETCH_WAIT: begin
                    state_r           <= IDLE;
                    data_valid        <= 1'b0;
                    instruction_valid <= 1'b0;
                end
                default: begin
                    state_r           <= IDLE;
                    data_valid        <= 1'b0;
                    instruction_valid <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state_r != IDLE);

endmodule

// File: tb/tb_memory_controller.sv
// Self-checking bench for memory_controller: directed cases plus randomized traffic
// checked against a word-array reference model with cycle-level expectations.
module tb_memory_controller;

    logic        clock;
    logic        reset;
    logic [15:0] PC;
    logic        fetch_request;
    logic [15:0] instruction;
    logic        instruction_valid;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] address;
    logic [15:0] write_data;
    logic [15:0] read_data;
    logic        data_valid;
    logic        busy;
    logic        error;

    int checks = 0;
    int errors = 0;

    logic [15:0] model_mem [0:4095];
    logic [15:0] model_rd;
    logic [15:0] model_instr;
    logic        model_err;

    memory_controller #(.ADDR_BITS(12)) dut (
        .clock             (clock),
        .reset             (reset),
        .PC                (PC),
        .fetch_request     (fetch_request),
        .instruction       (instruction),
        .instruction_valid (instruction_valid),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .address           (address),
        .write_data        (write_data),
        .read_data         (read_data),
        .data_valid        (data_valid),
        .busy              (busy),
        .error             (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic int widx(input logic [15:0] byte_addr);
        return int'(byte_addr[12:1]);
    endfunction

    // One request set from IDLE; expectations come from priority rules and the model array.
    task automatic run_access(input bit wr, input bit rd, input bit fe,
                              input logic [15:0] addr, input logic [15:0] wdata,
                              input logic [15:0] pc_in);
        int exp_dcyc;
        int exp_fcyc;
        exp_dcyc = (wr || rd) ? 1 : -1;
        exp_fcyc = fe ? ((wr || rd) ? 3 : 1) : -1;
        if (wr) begin
            model_mem[widx(addr)] = wdata;
            if (rd) model_err = 1'b1;
        end else if (rd) begin
            model_rd = model_mem[widx(addr)];
        end
        if ((wr || rd) && addr[0]) model_err = 1'b1;
        if (fe) begin
            model_instr = model_mem[widx(pc_in)];
            if (pc_in[0]) model_err = 1'b1;
        end

        @(negedge clock);
        mem_write     = wr;
        mem_read      = rd;
        fetch_request = fe;
        address       = addr;
        write_data    = wdata;
        PC            = pc_in;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(negedge clock);
            check_val("data_valid", data_valid, 32'(cyc == exp_dcyc));
            check_val("instruction_valid", instruction_valid, 32'(cyc == exp_fcyc));
            check_val("busy", busy, 32'((cyc == exp_dcyc) || (cyc == exp_fcyc)));
            if (data_valid) begin
                mem_write = 1'b0;
                mem_read  = 1'b0;
            end
            if (instruction_valid) fetch_request = 1'b0;
        end
        mem_write     = 1'b0;
        mem_read      = 1'b0;
        fetch_request = 1'b0;
        check_val("read_data", read_data, 32'(model_rd));
        check_val("instruction", instruction, 32'(model_instr));
        check_val("error", error, 32'(model_err));
    endtask

    function automatic logic [15:0] rand_addr(input bit allow_mis);
        logic [15:0] a;
        a        = 16'h0000;
        a[15:13] = 3'($urandom_range(0, 7));
        a[5:1]   = 5'($urandom_range(0, 31));
        a[0]     = allow_mis && ($urandom_range(0, 15) == 0);
        return a;
    endfunction

    task automatic rand_phase(input int n, input bit allow_err);
        int kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 5);
            case (kind)
                0: run_access(1'b1, 1'b0, 1'b0, rand_addr(allow_err), 16'($urandom), 16'h0000);
                1: run_access(1'b0, 1'b1, 1'b0, rand_addr(allow_err), 16'h0000, 16'h0000);
                2: run_access(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, rand_addr(allow_err));
                3: run_access(1'b0, 1'b1, 1'b1, rand_addr(allow_err), 16'h0000, rand_addr(allow_err));
                4: run_access(1'b1, 1'b0, 1'b1, rand_addr(allow_err), 16'($urandom), rand_addr(allow_err));
                default: run_access(1'b1, allow_err, 1'b0, rand_addr(allow_err), 16'($urandom), 16'h0000);
            endcase
        end
    endtask

    initial begin
        reset         = 1'b1;
        PC            = 16'h0000;
        fetch_request = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        address       = 16'h0000;
        write_data    = 16'h0000;
        model_rd      = 16'h0000;
        model_instr   = 16'h0000;
        model_err     = 1'b0;
        repeat (3) @(negedge clock);
        check_val("rst_instruction", instruction, 32'h0);
        check_val("rst_read_data", read_data, 32'h0);
        check_val("rst_ivalid", instruction_valid, 32'h0);
        check_val("rst_dvalid", data_valid, 32'h0);
        check_val("rst_busy", busy, 32'h0);
        check_val("rst_error", error, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) begin
            run_access(1'b1, 1'b0, 1'b0, 16'(i * 2), 16'($urandom), 16'h0000);
        end

        run_access(1'b1, 1'b0, 1'b0, 16'h0000, 16'hA123, 16'h0000);
        run_access(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000);
        check_val("tp_fetch_instr", instruction, 32'hA123);

        run_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'hBEEF, 16'h0000);
        run_access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
        check_val("tp_raw_read", read_data, 32'hBEEF);
        check_val("tp_raw_instr_kept", instruction, 32'hA123);

        run_access(1'b0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0000);
        check_val("tp_prio_error", error, 32'h0);

        rand_phase(150, 1'b0);
        check_val("clean_error", error, 32'h0);

        run_access(1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234, 16'h0000);
        check_val("tp_rw_error", error, 32'h1);
        run_access(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000, 16'h0000);
        check_val("tp_rw_data", read_data, 32'h1234);

        run_access(1'b1, 1'b0, 1'b0, 16'h0010, 16'hC0DE, 16'h0000);
        run_access(1'b0, 1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000);
        check_val("tp_misaligned", read_data, 32'hC0DE);
        run_access(1'b0, 1'b1, 1'b0, 16'h2010, 16'h0000, 16'h0000);
        check_val("tp_alias", read_data, 32'hC0DE);

        rand_phase(150, 1'b1);
        check_val("sticky_error", error, 32'h1);

        // Reset lands in the DATA_WAIT cycle of a read.
        @(negedge clock);
        mem_read = 1'b1;
        address  = 16'h0020;
        @(posedge clock);
        #1;
        reset    = 1'b1;
        mem_read = 1'b0;
        #1;
        check_val("midrst_dvalid", data_valid, 32'h0);
        check_val("midrst_read_data", read_data, 32'h0);
        check_val("midrst_busy", busy, 32'h0);
        check_val("midrst_error", error, 32'h0);
        check_val("midrst_instruction", instruction, 32'h0);
        model_rd    = 16'h0000;
        model_instr = 16'h0000;
        model_err   = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        run_access(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0000, 16'h0000);
        run_access(1'b0, 1'b1, 1'b1, 16'h0020, 16'h0000, 16'h0010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/memory_controller.md
# memory_controller

Memory responder for the NBBPU: serves the core's instruction fetches (PC) and data accesses (address/write_data) from a single-port synchronous word RAM. Sequences one RAM access at a time through a small state machine, with data requests taking priority over fetches, and returns results with one-cycle valid pulses. Sits between the NBBPU core and on-chip block RAM.

## Interface
- ADDR_BITS, 12, word-address width; RAM depth is 2^ADDR_BITS 16-bit words (8 KB at default).
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- PC  in  16  byte address of the instruction to fetch.
- fetch_request  in  1  level; held until instruction_valid.
- instruction  out  16  fetched word; holds last fetched value.
- instruction_valid  out  1  one-cycle pulse: instruction updated this cycle.
- mem_read  in  1  level data-read request; held until data_valid.
- mem_write  in  1  level data-write request; held until data_valid.
- address  in  16  byte address of the data access.
- write_data  in  16  data for writes.
- read_data  out  16  read result; holds last read value.
- data_valid  out  1  one-cycle pulse: read/write completed.
- busy  out  1  high when state is not IDLE.
- error  out  1  sticky protocol/alignment error flag.

## Operation
- States: IDLE, DATA_WAIT, FETCH_WAIT.
- Word address = byte address bits [ADDR_BITS:1]; bit 0 ignored; upper bits ignored (addresses wrap modulo RAM size).
- IDLE, mem_write=1: RAM[address] <= write_data at this edge; -> DATA_WAIT.
- IDLE, mem_read=1 (mem_write=0): issue RAM read of address; -> DATA_WAIT.
- IDLE, no data request, fetch_request=1: issue RAM read of PC; -> FETCH_WAIT.
- IDLE, no request: stay; no RAM access.
- DATA_WAIT: data_valid=1; read_data <= RAM output if the access was a read, unchanged for writes; -> IDLE.
- FETCH_WAIT: instruction_valid=1; instruction <= RAM output; -> IDLE.
- Requests present in a *_WAIT cycle are not sampled; the core drops the satisfied request on the valid pulse, and remaining requests are accepted in the following IDLE cycle.
- Priority: write > read > fetch. Data always before fetch so the executing instruction completes first.
- mem_read and mem_write both high in IDLE: write performed, read ignored, error set.
- Accepted access with address[0]=1 (data) or PC[0]=1 (fetch): access performed on truncated word address, error set.
- error clears only on reset.
- RAM contents are not affected by reset; no reset-time initialisation.

## Timing
- Reset values: state IDLE, instruction 16'h0000, read_data 16'h0000, instruction_valid 0, data_valid 0, busy 0, error 0.
- Reset asserted mid-access: immediately IDLE, valid pulse suppressed, outputs to reset values; a write already clocked into RAM persists.
- Latency: request seen in IDLE at cycle N -> valid pulse and updated data visible in cycle N+1.
- Throughput: at most one access per 2 cycles; fetch + data back-to-back = 4 cycles.
- busy high exactly in DATA_WAIT/FETCH_WAIT cycles, coincident with the valid pulse.
- instruction_valid and data_valid never high together.
- Read after write to same address returns the new value (minimum 2-cycle separation guarantees it).
- Outputs registered except busy (decoded from state register).

## Test plan
- Reset then fetch_request=1, PC=16'h0000 with RAM[0]=16'hA123 -> instruction_valid one cycle later, instruction=16'hA123, busy=1 that cycle, then IDLE.
- mem_write=1, address=16'h0010, write_data=16'hBEEF; then mem_read at 16'h0010 -> data_valid for each, read_data=16'hBEEF after second, instruction unchanged.
- fetch_request and mem_read asserted together in IDLE -> data_valid first (cycle N+1), instruction_valid at N+3; error stays 0.
- mem_read=mem_write=1, address=16'h0020, write_data=16'h1234 -> RAM[0x10 word]=16'h1234, single data_valid, error=1 and sticky through later clean accesses.
- Read at address=16'h0011 -> returns word at 16'h0010, error=1; read at 16'h2010 (ADDR_BITS=12) -> aliases to 16'h0010.
- Assert reset during DATA_WAIT of a read -> no data_valid, read_data=0, busy=0, error=0; previously written RAM data still readable after reset.
